// File: rtl/gap_fetch_pkg.sv
// Shared types and defaults for the word fetcher: FSM state encoding,
// bus width defaults and the FIFO pointer width helper.
package gap_fetch_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

    // Pointer width for a power-of-two FIFO; never narrower than one bit.
    function automatic int fifo_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_word_fetcher_if.sv
// Memory read port plus output word stream of the fetcher.
// master = fetcher side, slave = memory/consumer side.
interface mem_word_fetcher_if
    import gap_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        output ren, raddr, m_valid, m_data, m_last,
        input  rdata, m_ready
    );

    modport slave (
        input  ren, raddr, m_valid, m_data, m_last,
        output rdata, m_ready
    );
endinterface

// File: rtl/gap_fwft_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on o_data while
// the FIFO is non-empty. Push and pop in the same cycle are legal even
// when full or empty (a pop on empty is ignored).
module gap_fwft_fifo
    import gap_fetch_pkg::*;
#(
    parameter  int DATA_W     = DATA_W_DEF,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = fifo_ptr_w(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    assign o_data  = r_mem[r_rptr];
    assign o_count = r_count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage write.
    // NOTE: storage has no reset; the pointers alone define which entries
    // are valid, so clearing the array would only cost flops and fan-out.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/mem_word_fetcher.sv
// Burst word fetcher: on start, reads len consecutive words from base_addr
// out of a one-cycle-latency memory and streams them through a small FWFT
// buffer with a last flag. Reads are issued only when buffer space is
// guaranteed for every word already requested, so back-pressure never
// drops data.
module mem_word_fetcher
    import gap_fetch_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = ADDR_W + 1
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               busy,
    output logic               done,
    mem_word_fetcher_if.master bus
);

    localparam int PTR_W  = fifo_ptr_w(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NEED_W = CNT_W + 1;

    fetch_state_t      r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_ren;
    logic [ADDR_W-1:0] r_raddr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_issued;
    logic [LEN_W-1:0]  r_recv;
    logic              r_inflight;

    logic              w_accept;
    logic              w_push;
    logic              w_push_last;
    logic              w_pop;
    logic              w_head_last;
    logic [DATA_W:0]   w_head;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [NEED_W-1:0] w_need;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_final_hs;

    assign w_accept    = (r_state == IDLE) & start;
    assign w_push      = r_inflight;
    assign w_push_last = (r_recv == r_len - LEN_W'(1));
    assign w_pop       = ~w_fifo_empty & bus.m_ready;
    assign w_head_last = w_head[DATA_W];
    assign w_final_hs  = w_pop & w_head_last;

    // Each stored entry carries its last flag next to the data word.
    gap_fwft_fifo #(
        .DATA_W     (DATA_W + 1),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({w_push_last, bus.rdata}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    // Credit check: occupancy after this edge, plus the read returning next
    // cycle, plus the read about to be issued, must fit in the buffer.
    // NOTE: every signal in a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        w_need       = '0;
        w_issue      = 1'b0;
        w_last_issue = 1'b0;
        w_need = NEED_W'(w_fifo_count) + NEED_W'(w_push) - NEED_W'(w_pop)
               + NEED_W'(r_ren) + NEED_W'(1);
        if (r_state == FETCH && r_issued < r_len && w_need <= NEED_W'(FIFO_DEPTH)) begin
            w_issue      = 1'b1;
            w_last_issue = (r_issued + LEN_W'(1) == r_len);
        end
    end

    // Control FSM with registered busy/done/ren/raddr outputs.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ren    <= 1'b0;
            r_raddr  <= '0;
            r_len    <= '0;
            r_issued <= '0;
        end else begin
            r_done <= 1'b0;
            r_ren  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len  <= len;
                        r_busy <= 1'b1;
                        if (len == '0) begin
                            r_state <= DONE;
                        end else begin
                            // Buffer is empty here, so the first read is
                            // issued together with the capture.
                            r_ren    <= 1'b1;
                            r_raddr  <= base_addr;
                            r_issued <= LEN_W'(1);
                            r_state  <= (len == LEN_W'(1)) ? DRAIN : FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (w_issue) begin
                        r_ren    <= 1'b1;
                        r_raddr  <= r_raddr + ADDR_W'(1);
                        r_issued <= r_issued + LEN_W'(1);
                        if (w_last_issue) r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_final_hs) r_state <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Return path: flag the read issued last cycle and count returned words
    // so the last flag follows the word index, not the address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
            r_recv     <= '0;
        end else begin
            r_inflight <= r_ren;
            if (w_accept)    r_recv <= '0;
            else if (w_push) r_recv <= r_recv + LEN_W'(1);
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign bus.ren     = r_ren;
    assign bus.raddr   = r_raddr;
    assign bus.m_valid = ~w_fifo_empty;
    assign bus.m_data  = w_fifo_empty ? '0 : w_head[DATA_W-1:0];
    assign bus.m_last  = ~w_fifo_empty & w_head_last;

endmodule

// File: tb/tb_mem_word_fetcher.sv
// Directed bench for mem_word_fetcher: memory model, stream monitor with an
// independent buffer-occupancy model, and hand-derived expectations.
module tb_mem_word_fetcher;
    import gap_fetch_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = ADDR_W + 1;
    localparam int BUDGET = 400;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              start     = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  len       = '0;
    logic              busy;
    logic              done;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    // Monitor state (per burst)
    logic [ADDR_W-1:0] addr_q [$];
    logic [DATA_W:0]   rx_q   [$];
    int ren_cnt, first_ren, last_ren, first_valid;
    int done_cnt, done_at, last_hs, max_occ, busy_cycles;
    bit saw_full;
    // Monitor state (whole run)
    int  model_cnt   = 0;
    bit  prev_ren    = 1'b0;
    bit  prev_stall  = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    int  valid_err   = 0;
    int  stab_err    = 0;
    int  full_ren_err = 0;

    mem_word_fetcher_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_word_fetcher #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5A5, ~a, a, a + 16'hC0DE};
    endfunction

    always #5 clk = ~clk;

    // Cycle index of the current clock period.
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory with one-cycle read latency.
    always @(posedge clk) if (bus.ren) bus.rdata <= word_of(bus.raddr);

    task automatic check(input string tag, input logic [DATA_W:0] got, input logic [DATA_W:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        addr_q.delete();
        rx_q.delete();
        ren_cnt     = 0;
        first_ren   = -1;
        last_ren    = -1;
        first_valid = -1;
        done_cnt    = 0;
        done_at     = -1;
        last_hs     = -1;
        max_occ     = 0;
        busy_cycles = 0;
        saw_full    = 1'b0;
    endtask

    // Mid-cycle monitor: records traffic and tracks expected buffer occupancy.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                model_cnt  = 0;
                prev_ren   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (bus.ren) begin
                    addr_q.push_back(bus.raddr);
                    if (ren_cnt == 0) first_ren = cyc;
                    last_ren = cyc;
                    ren_cnt++;
                end
                if (busy) busy_cycles++;
                if (bus.m_valid && first_valid < 0) first_valid = cyc;
                if (bus.m_valid !== (model_cnt != 0)) valid_err++;
                if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data)) stab_err++;
                if (model_cnt + int'(prev_ren) > max_occ) max_occ = model_cnt + int'(prev_ren);
                if (model_cnt == DEPTH) begin
                    saw_full = 1'b1;
                    if (bus.ren) full_ren_err++;
                end
                if (bus.m_valid && bus.m_ready) begin
                    rx_q.push_back({bus.m_last, bus.m_data});
                    last_hs = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_at = cyc;
                end
                prev_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
                model_cnt  = model_cnt + int'(prev_ren) - int'(bus.m_valid && bus.m_ready);
                prev_ren   = bus.ren;
            end
        end
    end

    // One burst: start pulse, optional second start at offset dup_at,
    // m_ready always high or high one cycle in three.
    task automatic run_burst(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n,
                             input bit slow, input int dup_at, output int s_cyc);
        bit finished;
        finished = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        base_addr   = b;
        len         = n;
        start       = 1'b1;
        bus.m_ready = 1'b1;
        s_cyc       = cyc;
        for (int k = 1; k < BUDGET && !finished; k++) begin
            @(posedge clk); #1;
            start = (k == dup_at);
            if (k == dup_at) begin
                base_addr = 16'h0300;
                len       = 17'd3;
            end
            bus.m_ready = !slow || (k % 3 == 0);
            if (done_cnt > 0 && cyc >= done_at + 4) finished = 1'b1;
        end
        start = 1'b0;
        check("burst_terminates", finished, 1'b1);
    endtask

    // Compare recorded addresses and stream words against base..base+n-1.
    task automatic check_stream(input string tag, input logic [ADDR_W-1:0] b, input int n);
        int aerr;
        int derr;
        logic [ADDR_W-1:0] a;
        aerr = 0;
        derr = 0;
        check({tag, "_ren_cnt"}, addr_q.size(), n);
        check({tag, "_rx_cnt"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            a = b + ADDR_W'(i);
            if (i >= addr_q.size() || addr_q[i] !== a) aerr++;
            if (i >= rx_q.size() || rx_q[i] !== {(i == n - 1), word_of(a)}) derr++;
        end
        check({tag, "_addr_seq"}, aerr, 0);
        check({tag, "_data_seq"}, derr, 0);
    endtask

    initial begin
        int s;
        bus.m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    busy,        1'b0);
        check("rst_done",    done,        1'b0);
        check("rst_ren",     bus.ren,     1'b0);
        check("rst_raddr",   bus.raddr,   16'h0000);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_data",  bus.m_data,  64'h0);
        check("rst_m_last",  bus.m_last,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full-rate burst
        run_burst(16'h0010, 17'd8, 1'b0, 0, s);
        check_stream("t1", 16'h0010, 8);
        check("t1_first_ren",   first_ren, s + 1);
        check("t1_ren_span",    last_ren - first_ren, 7);
        check("t1_first_valid", first_valid, s + 3);
        check("t1_done_cnt",    done_cnt, 1);
        check("t1_done_after",  (done_at > last_hs) && (done_at <= last_hs + 2), 1'b1);
        check("t1_busy_end",    busy, 1'b0);

        // Address wrap
        run_burst(16'hFFFE, 17'd4, 1'b0, 0, s);
        check_stream("t2", 16'hFFFE, 4);
        check("t2_done_cnt", done_cnt, 1);

        // Back-pressure
        run_burst(16'h0200, 17'd16, 1'b1, 0, s);
        check_stream("t3", 16'h0200, 16);
        check("t3_occ_le_depth", max_occ <= DEPTH, 1'b1);
        check("t3_reached_full", saw_full, 1'b1);
        check("t3_done_cnt",     done_cnt, 1);

        // Zero-length burst with a start during the done window
        run_burst(16'h0400, 17'd0, 1'b0, 1, s);
        check("t4_done_at",      done_at, s + 2);
        check("t4_done_cnt",     done_cnt, 1);
        check("t4_no_ren",       ren_cnt, 0);
        check("t4_no_valid",     first_valid, -1);
        check("t4_busy_cycles",  busy_cycles, 1);

        // Single word with a start while busy
        run_burst(16'h0040, 17'd1, 1'b0, 2, s);
        check_stream("t5", 16'h0040, 1);
        check("t5_first_valid", first_valid, s + 3);
        check("t5_done_cnt",    done_cnt, 1);

        // Reset mid-burst
        clear_mon();
        @(posedge clk); #1;
        base_addr   = 16'h0050;
        len         = 17'd8;
        start       = 1'b1;
        bus.m_ready = 1'b1;
        s = 0;
        for (int k = 0; k < BUDGET; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            s = k;
            if (rx_q.size() >= 3) break;
        end
        check("t6_reached_3_words", rx_q.size() >= 3, 1'b1);
        check("t6_read_in_flight",  bus.ren, 1'b1);
        rst = 1'b1;
        #1;
        check("t6_busy",    busy,        1'b0);
        check("t6_done",    done,        1'b0);
        check("t6_ren",     bus.ren,     1'b0);
        check("t6_raddr",   bus.raddr,   16'h0000);
        check("t6_m_valid", bus.m_valid, 1'b0);
        check("t6_m_data",  bus.m_data,  64'h0);
        check("t6_m_last",  bus.m_last,  1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        run_burst(16'h0100, 17'd2, 1'b0, 0, s);
        check_stream("t6", 16'h0100, 2);
        check("t6_done_cnt", done_cnt, 1);

        // Whole-run stream properties
        check("m_valid_vs_model", valid_err, 0);
        check("m_data_held",      stab_err, 0);
        check("no_ren_when_full", full_ren_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
